// File: rtl/paint_pkg.sv
// rtl/paint_pkg.sv - shared writer indices, arbiter states and index helpers
package paint_pkg;

    localparam logic [1:0] WR_PAINT  = 2'd0;
    localparam logic [1:0] WR_CURSOR = 2'd1;
    localparam logic [1:0] WR_PALETA = 2'd2;
    localparam int         N_WRITERS = 3;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_WRITE = 1'b1
    } arb_state_t;

    // Successor of a writer index in round-robin order (wraps 2 -> 0).
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        case (idx)
            WR_PAINT:  return WR_CURSOR;
            WR_CURSOR: return WR_PALETA;
            default:   return WR_PAINT;
        endcase
    endfunction

    // One-hot vector for a writer index.
    function automatic logic [N_WRITERS-1:0] onehot3(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// rtl/rr_pick3.sv - combinational three-way round-robin picker
module rr_pick3
    import paint_pkg::*;
(
    input  logic [N_WRITERS-1:0] req,
    input  logic [1:0]           last,
    output logic                 valid,
    output logic [1:0]           idx
);

    logic [1:0] cand1;
    logic [1:0] cand2;
    logic [1:0] cand3;

    // Scan last+1, last+2, last+3 and take the first requester found.
    always_comb begin
        cand1 = next_idx(last);
        cand2 = next_idx(cand1);
        cand3 = next_idx(cand2);
        valid = |req;
        idx   = cand1;
        if (req[cand1]) begin
            idx = cand1;
        end else if (req[cand2]) begin
            idx = cand2;
        end else if (req[cand3]) begin
            idx = cand3;
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// rtl/fb_write_arbiter.sv - round-robin arbiter for the framebuffer write port
module fb_write_arbiter
    import paint_pkg::*;
#(
    parameter int MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [23:0] req_x,
    input  logic [23:0] req_y,
    input  logic [23:0] req_data,
    input  logic        mem_ready,
    output logic [2:0]  gnt,
    output logic [2:0]  ack,
    output logic        wr_en,
    output logic [7:0]  wr_x,
    output logic [7:0]  wr_y,
    output logic [7:0]  wr_data,
    output logic        busy
);

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    arb_state_t state;
    logic [1:0] owner;
    logic [1:0] last_owner;
    logic [7:0] burst_cnt;

    logic       pick_valid;
    logic [1:0] pick_idx;
    logic       owner_req;
    logic       beat;
    logic       others_pending;
    logic [7:0] sel_x;
    logic [7:0] sel_y;
    logic [7:0] sel_data;

    rr_pick3 u_pick (
        .req   (req),
        .last  (last_owner),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Owner's request drives the strobe; a beat is a strobe the memory accepts.
    always_comb begin
        owner_req      = req[owner];
        wr_en          = (state == ARB_WRITE) && owner_req;
        beat           = wr_en && mem_ready;
        ack            = beat ? onehot3(owner) : 3'b000;
        others_pending = |(req & ~onehot3(owner));
    end

    // Route the owner's coordinate and colour lanes, forced to zero when not writing.
    always_comb begin
        case (owner)
            2'd1: begin
                sel_x    = req_x[15:8];
                sel_y    = req_y[15:8];
                sel_data = req_data[15:8];
            end
            2'd2: begin
                sel_x    = req_x[23:16];
                sel_y    = req_y[23:16];
                sel_data = req_data[23:16];
            end
            default: begin
                sel_x    = req_x[7:0];
                sel_y    = req_y[7:0];
                sel_data = req_data[7:0];
            end
        endcase
        wr_x    = wr_en ? sel_x    : 8'd0;
        wr_y    = wr_en ? sel_y    : 8'd0;
        wr_data = wr_en ? sel_data : 8'd0;
    end

    // Grant FSM: arbitrate in IDLE, stream beats in WRITE, release on drop or burst limit.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            owner      <= WR_PAINT;
            last_owner <= WR_PALETA;
            burst_cnt  <= 8'd0;
            gnt        <= 3'b000;
            busy       <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        owner     <= pick_idx;
                        gnt       <= onehot3(pick_idx);
                        busy      <= 1'b1;
                        burst_cnt <= 8'd0;
                        state     <= ARB_WRITE;
                    end
                end
                ARB_WRITE: begin
                    if (!owner_req) begin
                        gnt        <= 3'b000;
                        busy       <= 1'b0;
                        last_owner <= owner;
                        state      <= ARB_IDLE;
                    end else if (beat) begin
                        if (burst_cnt == BURST_LAST) begin
                            // At the limit: yield only if someone else is waiting.
                            if (others_pending) begin
                                gnt        <= 3'b000;
                                busy       <= 1'b0;
                                last_owner <= owner;
                                state      <= ARB_IDLE;
                            end
                        end else begin
                            burst_cnt <= burst_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Shares the single framebuffer write port among the three paint-side writers: pixel paint (index 0), cursor overlay (index 1) and palette cursor (index 2). Each writer holds a request with pixel coordinates and data. The arbiter grants one writer at a time, round-robin, and issues its beats to the memory port with per-beat acknowledge. A grant may be kept for a burst of up to MAX_BURST beats before other writers get a turn. It sits between the paint control FSM plus cursor engines and the framebuffer memory.

## Interface
Parameters:
- MAX_BURST, 16: maximum beats per grant while another request is pending (2..255).

Ports:
- clk  in  1  system clock; all flops update on negedge clk, as in the rest of the paint path.
- rst  in  1  asynchronous, active-low reset.
- req  in  3  per-writer request; bit i = writer i; held high for the whole burst.
- req_x  in  24  x coordinate; writer i on [8i+7:8i].
- req_y  in  24  y coordinate; same packing.
- req_data  in  24  pixel colour; same packing.
- mem_ready  in  1  memory accepts a write this cycle.
- gnt  out  3  registered one-hot grant; all zeros when idle.
- ack  out  3  combinational; one-hot beat-accepted pulse to the owner.
- wr_en  out  1  combinational memory write strobe.
- wr_x, wr_y, wr_data  out  8 each  combinational; the owner's fields, zero when wr_en=0.
- busy  out  1  registered; high in WRITE.

## Operation
- State machine states: IDLE and WRITE.
- Registers: owner[1:0], last_owner[1:0], burst_cnt[7:0].
- IDLE:
  - If req != 0, pick the first set bit scanning last_owner+1, last_owner+2, last_owner+3 (indices mod 3).
  - Load owner, set gnt[owner], clear burst_cnt, go to WRITE.
  - If req == 0, stay in IDLE.
- WRITE:
  - wr_en = req[owner].
  - ack[owner] = wr_en & mem_ready. A beat completes on each edge where this is high; burst_cnt increments on that edge.
- Release from WRITE to IDLE happens on the edge where either condition holds:
  - req[owner]=0 (the writer ended its burst, with or without a pending beat);
  - a beat completes with burst_cnt == MAX_BURST-1 and (req & ~onehot(owner)) != 0.
- On release: gnt cleared, last_owner <= owner. Re-arbitration takes one IDLE cycle.
- If no other writer is pending, burst_cnt saturates at MAX_BURST-1 and the owner keeps the grant.
- Writer contract:
  - fields stay stable while req is high and ack is low;
  - on ack it may present the next pixel, or drop req for that edge.
- Requests from non-owners are ignored until the next IDLE.
- Coordinates and data are passed through unmodified; no width conversion.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, owner=0, last_owner=2 (writer 0 has first priority), burst_cnt=0, gnt=0, busy=0;
  - combinationally ack=0, wr_en=0, wr_x=wr_y=wr_data=0.
- Reset mid-burst aborts at once; a beat without ack is not written.
- Grant latency: req sampled high in IDLE at edge k gives gnt/busy high after edge k. The first wr_en is in the cycle after edge k.
- Throughput: one beat per cycle while mem_ready=1 and req is held.
- Hand-off gap: exactly one idle cycle (wr_en=0) between grants.
- Simultaneous requests in IDLE: the round-robin order decides; no writer waits more than two foreign grants.
- req[owner] dropping on the same edge as a final beat's ack: that beat counts, then release.
- mem_ready low: wr_en stays high and the fields are held until accepted.

## Structure
- Shared package paint_pkg holds:
  - writer index constants WR_PAINT=0, WR_CURSOR=1, WR_PALETA=2, and N_WRITERS=3;
  - state encoding ARB_IDLE, ARB_WRITE.
- One sub-module: rr_pick3, a combinational round-robin picker.
  - Inputs: req[2:0], last[1:0].
  - Outputs: valid, idx[1:0].

## Test plan
- Reset, then req=3'b001 with x=5, y=7, data=8'hA3 and mem_ready=1 → gnt=001 after one edge; next cycle wr_en=1, wr_x=5, wr_y=7, wr_data=A3, ack=001.
- req=3'b111 held from reset with mem_ready=1 and MAX_BURST=4 → owners are 0, 1, 2, 0, …; each grant gives exactly 4 acks followed by one cycle with wr_en=0.
- Only writer 1 requests for 40 beats → grant never drops and 40 acks arrive back to back.
- Writer 2 owns, mem_ready=0 for 3 cycles → wr_en held high, fields stable, ack=0; the beat completes on the 4th cycle.
- Writer 0 drops req with no beat pending → IDLE next edge; writer 2 pending is granted, then last_owner=2 ordering is checked.
- rst asserted mid-burst between edges → gnt=0, wr_en=0 immediately; after release, writer 0 wins a three-way tie.
